pc_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the IF stage. Owns the architectural PC register and drives `PC_address` into the PC adder, consuming its `PC_added` (PC+4) and `PC_jump` (branch target) results. It issues single-outstanding fetch requests to instruction memory over a valid/ready handshake. Returned instructions are presented to the IF/ID register with stall and branch-flush handling.

---
 rtl/pc_fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// -----------------------------------------------------------------------------
// Instruction-fetch controller for the IF stage. Owns the architectural PC,
// issues one outstanding fetch at a time to instruction memory over a
// valid/ready handshake, and presents returned instructions to the IF/ID
// register. Handles hazard stalls and branch redirects. A redirect always
// wins over a stall. A response that belongs to a squashed fetch is dropped
// and never raises inst_valid.
//
// Ports
//   clk, rst_n    : clock and asynchronous active-low reset
//   PC_added      : PC_address + 4 from the external PC adder
//   PC_jump       : redirect target. Valid while branch_taken is high.
//   branch_taken  : redirect request from EXE (highest priority)
//   stall         : hazard unit asks IF/ID to hold
//   PC_address    : current PC register, fed to the PC adder
//   im_req_valid  : fetch request valid
//   im_req_ready  : memory accepts the request
//   im_req_addr   : fetch address, held stable while the request waits
//   im_rsp_valid  : fetch data valid
//   im_rsp_data   : fetched instruction word
//   inst_valid    : instruction available to IF/ID
//   inst, inst_PC : instruction word and its PC
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int                     DATA_SIZE = 32,
    parameter logic [DATA_SIZE-1:0]   RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_SIZE-1:0]  PC_added,
    input  logic [DATA_SIZE-1:0]  PC_jump,
    input  logic                  branch_taken,
    input  logic                  stall,
    output logic [DATA_SIZE-1:0]  PC_address,
    output logic                  im_req_valid,
    input  logic                  im_req_ready,
    output logic [DATA_SIZE-1:0]  im_req_addr,
    input  logic                  im_rsp_valid,
    input  logic [DATA_SIZE-1:0]  im_rsp_data,
    output logic                  inst_valid,
    output logic [DATA_SIZE-1:0]  inst,
    output logic [DATA_SIZE-1:0]  inst_PC
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [DATA_SIZE-1:0]  req_addr, req_addr_nx;
    logic [DATA_SIZE-1:0]  pc_nx;
    logic                  flush_pend, flush_pend_nx;
    logic                  inst_valid_nx;
    logic                  capture;

    assign im_req_valid = (state == REQ);
    assign im_req_addr  = req_addr;

    // Next-state and next-register logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would infer a latch.
        state_nx      = state;
        pc_nx         = PC_address;
        req_addr_nx   = req_addr;
        flush_pend_nx = flush_pend;
        inst_valid_nx = inst_valid;
        capture       = 1'b0;

        unique case (state)
            IDLE: begin
                state_nx = REQ;
                if (branch_taken) begin
                    pc_nx       = PC_jump;
                    req_addr_nx = PC_jump;
                end else begin
                    req_addr_nx = PC_address;
                end
            end

            REQ: begin
                if (im_req_ready) begin
                    // The accepted fetch is stale if a redirect arrived while
                    // it waited, or arrives now. Its response must be dropped.
                    state_nx      = (branch_taken || flush_pend) ? DROP : WAIT;
                    flush_pend_nx = 1'b0;
                    if (branch_taken) begin
                        pc_nx = PC_jump;
                    end
                end else if (branch_taken) begin
                    // The request address must stay stable, so only the PC
                    // moves. The squash is remembered until acceptance.
                    pc_nx         = PC_jump;
                    flush_pend_nx = 1'b1;
                end
            end

            WAIT: begin
                if (im_rsp_valid) begin
                    if (branch_taken) begin
                        pc_nx       = PC_jump;
                        req_addr_nx = PC_jump;
                        state_nx    = REQ;
                    end else begin
                        capture       = 1'b1;
                        inst_valid_nx = 1'b1;
                        state_nx      = HOLD;
                    end
                end else if (branch_taken) begin
                    pc_nx    = PC_jump;
                    state_nx = DROP;
                end
            end

            DROP: begin
                if (im_rsp_valid) begin
                    state_nx    = REQ;
                    req_addr_nx = branch_taken ? PC_jump : PC_address;
                    if (branch_taken) begin
                        pc_nx = PC_jump;
                    end
                end else if (branch_taken) begin
                    pc_nx = PC_jump;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    inst_valid_nx = 1'b0;
                    pc_nx         = PC_jump;
                    req_addr_nx   = PC_jump;
                    state_nx      = REQ;
                end else if (!stall) begin
                    inst_valid_nx = 1'b0;
                    pc_nx         = PC_added;
                    req_addr_nx   = PC_added;
                    state_nx      = REQ;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            PC_address <= RESET_PC;
            req_addr   <= RESET_PC;
            flush_pend <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_PC    <= '0;
        end else begin
            state      <= state_nx;
            PC_address <= pc_nx;
            req_addr   <= req_addr_nx;
            flush_pend <= flush_pend_nx;
            inst_valid <= inst_valid_nx;
            if (capture) begin
                inst    <= im_rsp_data;
                inst_PC <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl. The PC adder is modelled as
// PC_address + 4. Inputs change and outputs are sampled 1 ns after each
// rising edge.
module tb_pc_fetch_ctrl;

    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  PC_added;
    logic [DW-1:0]  PC_jump;
    logic           branch_taken;
    logic           stall;
    logic [DW-1:0]  PC_address;
    logic           im_req_valid;
    logic           im_req_ready;
    logic [DW-1:0]  im_req_addr;
    logic           im_rsp_valid;
    logic [DW-1:0]  im_rsp_data;
    logic           inst_valid;
    logic [DW-1:0]  inst;
    logic [DW-1:0]  inst_PC;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign PC_added = PC_address + 32'd4;

    pc_fetch_ctrl #(.DATA_SIZE(DW), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC_added     (PC_added),
        .PC_jump      (PC_jump),
        .branch_taken (branch_taken),
        .stall        (stall),
        .PC_address   (PC_address),
        .im_req_valid (im_req_valid),
        .im_req_ready (im_req_ready),
        .im_req_addr  (im_req_addr),
        .im_rsp_valid (im_rsp_valid),
        .im_rsp_data  (im_rsp_data),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_PC      (inst_PC)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept the current request and return one 0-wait-state response.
    // On return the DUT is in HOLD, unless a branch is pending.
    task automatic fetch(input logic [DW-1:0] data);
        im_req_ready = 1'b1;
        step();
        im_req_ready = 1'b0;
        im_rsp_valid = 1'b1;
        im_rsp_data  = data;
        step();
        im_rsp_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_valid"},  {31'd0, im_req_valid}, 32'd0);
        check({tag, "_inst_valid"}, {31'd0, inst_valid},   32'd0);
        check({tag, "_pc"},         PC_address,            32'h0);
        check({tag, "_req_addr"},   im_req_addr,           32'h0);
        check({tag, "_inst"},       inst,                  32'h0);
        check({tag, "_inst_pc"},    inst_PC,               32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        PC_jump      = '0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        im_req_ready = 1'b0;
        im_rsp_valid = 1'b0;
        im_rsp_data  = '0;

        // Reset state
        #3;
        check_reset_state("rst");
        #9 rst_n = 1'b1;

        // Boot: first request at RESET_PC, one cycle after the first edge
        step();
        check("boot_valid", {31'd0, im_req_valid}, 32'd1);
        check("boot_addr",  im_req_addr,           32'h0);
        im_req_ready = 1'b1;
        step();
        check("boot_wait_valid", {31'd0, im_req_valid}, 32'd0);
        im_req_ready = 1'b0;
        im_rsp_valid = 1'b1;
        im_rsp_data  = 32'h0000_0013;
        step();
        im_rsp_valid = 1'b0;
        check("boot_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("boot_inst",       inst,                32'h0000_0013);
        check("boot_inst_pc",    inst_PC,             32'h0);
        step();
        check("boot_next_addr",  im_req_addr,           32'h4);
        check("boot_next_valid", {31'd0, im_req_valid}, 32'd1);
        check("boot_consumed",   {31'd0, inst_valid},   32'd0);

        // Second fetch at 4, then backpressure on the request at 8
        fetch(32'h1111_0004);
        check("f4_inst_pc", inst_PC, 32'h4);
        check("f4_inst",    inst,    32'h1111_0004);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", {31'd0, im_req_valid}, 32'd1);
            check("bp_addr",  im_req_addr,           32'h8);
        end
        im_req_ready = 1'b1;
        step();
        im_req_ready = 1'b0;
        check("bp_accepted", {31'd0, im_req_valid}, 32'd0);
        im_rsp_valid = 1'b1;
        im_rsp_data  = 32'h2222_0008;
        step();
        im_rsp_valid = 1'b0;
        check("bp_inst_pc", inst_PC, 32'h8);
        step();
        check("req_c_addr", im_req_addr, 32'hC);

        // Stall held for 4 cycles in HOLD
        stall = 1'b1;
        fetch(32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            check("stall_inst_valid", {31'd0, inst_valid},   32'd1);
            check("stall_inst",       inst,                  32'hDEAD_BEEF);
            check("stall_inst_pc",    inst_PC,               32'hC);
            check("stall_no_req",     {31'd0, im_req_valid}, 32'd0);
            step();
        end
        stall = 1'b0;
        step();
        check("unstall_valid", {31'd0, im_req_valid}, 32'd1);
        check("unstall_addr",  im_req_addr,           32'h10);

        // Branch while WAIT: the outstanding response is dropped
        im_req_ready = 1'b1;
        step();
        im_req_ready = 1'b0;
        branch_taken = 1'b1;
        PC_jump      = 32'h100;
        step();
        branch_taken = 1'b0;
        check("bw_pc",         PC_address,            32'h100);
        check("bw_no_req",     {31'd0, im_req_valid}, 32'd0);
        check("bw_inst_valid", {31'd0, inst_valid},   32'd0);
        im_rsp_valid = 1'b1;
        im_rsp_data  = 32'hBAD0_0010;
        step();
        im_rsp_valid = 1'b0;
        check("bw_drop_inst_valid", {31'd0, inst_valid},   32'd0);
        check("bw_req_valid",       {31'd0, im_req_valid}, 32'd1);
        check("bw_req_addr",        im_req_addr,           32'h100);

        // Branch while REQ with ready low: address stays until accepted
        branch_taken = 1'b1;
        PC_jump      = 32'h200;
        step();
        branch_taken = 1'b0;
        check("br_hold_valid", {31'd0, im_req_valid}, 32'd1);
        check("br_hold_addr",  im_req_addr,           32'h100);
        check("br_pc",         PC_address,            32'h200);
        im_req_ready = 1'b1;
        step();
        im_req_ready = 1'b0;
        check("br_drop_no_req", {31'd0, im_req_valid}, 32'd0);
        im_rsp_valid = 1'b1;
        im_rsp_data  = 32'hBAD0_0100;
        step();
        im_rsp_valid = 1'b0;
        check("br_drop_inst_valid", {31'd0, inst_valid},   32'd0);
        check("br_req_valid",       {31'd0, im_req_valid}, 32'd1);
        check("br_req_addr",        im_req_addr,           32'h200);

        // Branch together with the response in WAIT
        im_req_ready = 1'b1;
        step();
        im_req_ready = 1'b0;
        branch_taken = 1'b1;
        PC_jump      = 32'h40;
        im_rsp_valid = 1'b1;
        im_rsp_data  = 32'hBAD0_0200;
        step();
        branch_taken = 1'b0;
        im_rsp_valid = 1'b0;
        check("bs_inst_valid", {31'd0, inst_valid},   32'd0);
        check("bs_req_valid",  {31'd0, im_req_valid}, 32'd1);
        check("bs_req_addr",   im_req_addr,           32'h40);

        // Asynchronous reset in the middle of WAIT
        im_req_ready = 1'b1;
        step();
        im_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        im_rsp_valid = 1'b1;
        im_rsp_data  = 32'hBAD0_0040;
        #3 rst_n = 1'b1;
        step();
        im_rsp_valid = 1'b0;
        check("arst_inst_valid", {31'd0, inst_valid},   32'd0);
        check("arst_req_valid",  {31'd0, im_req_valid}, 32'd1);
        check("arst_req_addr",   im_req_addr,           32'h0);

        // Address wrap: PC_added from FFFF_FFFC is 0
        im_req_ready = 1'b1;
        step();
        im_req_ready = 1'b0;
        branch_taken = 1'b1;
        PC_jump      = 32'hFFFF_FFFC;
        im_rsp_valid = 1'b1;
        step();
        branch_taken = 1'b0;
        im_rsp_valid = 1'b0;
        check("wrap_req_addr", im_req_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0033);
        check("wrap_inst_pc", inst_PC, 32'hFFFF_FFFC);
        check("wrap_inst",    inst,    32'h0000_0033);
        step();
        check("wrap_next_addr", im_req_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
